// File: rtl/button_pulser_pkg.sv
// Shared definitions for the button pulser: per-channel FSM state encoding
// and the sizing rule for the per-channel timer.
// Latency: n/a (package). Backpressure: n/a.
package button_pulser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_HELD         = 3'd2,
    ST_REPEAT       = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } btn_state_t;

  // Timer must be able to hold the largest threshold it is compared against.
  function automatic int timer_width(input int unsigned a,
                                     input int unsigned b,
                                     input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchronizer, debounce FSM, optional hold-to-repeat.
// Latency: press pulse/level rise DEBOUNCE_CYCLES+2 edges after the raw change.
// Backpressure: none; pulses are single-cycle and never queued.
// Ports: clk, resetn (sync, active-low), btn_in (raw async), pulse, level.
module button_debounce
  import button_pulser_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_in,
  output logic pulse,
  output logic level
);

  localparam int TW = timer_width(32'(DEBOUNCE_CYCLES), 32'(REPEAT_DELAY),
                                  32'(REPEAT_PERIOD));
  localparam logic [TW-1:0] DB_T  = TW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] RD_T  = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] RP_T  = TW'(REPEAT_PERIOD);
  localparam logic [TW-1:0] T_ONE = TW'(1);

  logic          sync_meta;
  logic          sync_in;
  btn_state_t    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt, timer_inc;
  logic          pulse_nxt, level_nxt;

  // Saturating increment: a long hold on the mode channel must not wrap.
  assign timer_inc = (timer == {TW{1'b1}}) ? timer : timer + T_ONE;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_meta <= 1'b0;
      sync_in   <= 1'b0;
      state     <= ST_IDLE;
      timer     <= '0;
      pulse     <= 1'b0;
      level     <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      sync_in   <= sync_meta;
      state     <= state_nxt;
      timer     <= timer_nxt;
      pulse     <= pulse_nxt;
      level     <= level_nxt;
    end
  end

  // Every accepted transition reloads the timer with 1 so that each
  // threshold measures cycles from the edge where that transition happened.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer_inc;
    pulse_nxt = 1'b0;
    level_nxt = level;
    case (state)
      ST_IDLE: begin
        timer_nxt = '0;
        if (sync_in) begin
          state_nxt = ST_PRESS_WAIT;
          timer_nxt = T_ONE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_in) begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end else if (timer >= DB_T) begin
          state_nxt = ST_HELD;
          timer_nxt = T_ONE;
          pulse_nxt = 1'b1;
          level_nxt = 1'b1;
        end
      end
      ST_HELD: begin
        if (!sync_in) begin
          state_nxt = ST_RELEASE_WAIT;
          timer_nxt = T_ONE;
        end else if (REPEAT_EN && (timer >= RD_T)) begin
          state_nxt = ST_REPEAT;
          timer_nxt = T_ONE;
          pulse_nxt = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!sync_in) begin
          state_nxt = ST_RELEASE_WAIT;
          timer_nxt = T_ONE;
        end else if (timer >= RP_T) begin
          timer_nxt = T_ONE;
          pulse_nxt = 1'b1;
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync_in) begin
          // Release bounce rejected: back to HELD with the repeat delay restarted.
          state_nxt = ST_HELD;
          timer_nxt = T_ONE;
        end else if (timer >= DB_T) begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
          level_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/button_pulser.sv
// Conditions the mode and count push-buttons into single-cycle pulses plus levels.
// Latency: press pulse DEBOUNCE_CYCLES+2 cycles after the raw edge; count repeats after.
// Backpressure: none; consumer must take each pulse in the cycle it is asserted.
// Ports: clk, resetn, btn_mode_in/btn_count_in (raw), mode_switch/ext_counter
// (pulses), btn_mode_level/btn_count_level (debounced levels).
module button_pulser
  import button_pulser_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd2500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_mode_in,
  input  logic btn_count_in,
  output logic mode_switch,
  output logic ext_counter,
  output logic btn_mode_level,
  output logic btn_count_level
);

  // Mode button toggles a setting, so holding it must not auto-repeat.
  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (1'b0),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_mode (
    .clk    (clk),
    .resetn (resetn),
    .btn_in (btn_mode_in),
    .pulse  (mode_switch),
    .level  (btn_mode_level)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_EN       (1'b1),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_count (
    .clk    (clk),
    .resetn (resetn),
    .btn_in (btn_count_in),
    .pulse  (ext_counter),
    .level  (btn_count_level)
  );

endmodule

// File: tb/tb_button_pulser.sv
module tb_button_pulser;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic resetn;
  logic btn_mode_in, btn_count_in;
  logic mode_switch, ext_counter, btn_mode_level, btn_count_level;

  always #5 clk = ~clk;

  button_pulser #(
    .DEBOUNCE_CYCLES (16'(DB)),
    .REPEAT_DELAY    (24'(RD)),
    .REPEAT_PERIOD   (24'(RP))
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .btn_mode_in     (btn_mode_in),
    .btn_count_in    (btn_count_in),
    .mode_switch     (mode_switch),
    .ext_counter     (ext_counter),
    .btn_mode_level  (btn_mode_level),
    .btn_count_level (btn_count_level)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic chk_q(input string nm, input int act[$], input int exp[$]);
    chk({nm, " count"}, act.size(), exp.size());
    for (int i = 0; i < act.size() && i < exp.size(); i++)
      chk($sformatf("%s[%0d] t", nm, i), act[i], exp[i]);
  endtask

  // Reference model: a level is accepted once the synchronized input has
  // disagreed with it for DB+1 consecutive edges; a rising acceptance pulses.
  // While held (count channel), pulses follow RD then every RP edges counted
  // from the last pulse or from the edge a release bounce was rejected.
  bit m_raw[2], m_s1[2], m_s2[2], m_lvl[2], m_pul[2], m_ph[2];
  int m_cnt[2], m_since[2];

  always @(posedge clk) begin
    m_raw[0] = btn_mode_in;
    m_raw[1] = btn_count_in;
    for (int c = 0; c < 2; c++) begin
      if (!resetn) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_pul[c] = 0;
        m_ph[c] = 0; m_cnt[c] = 0; m_since[c] = 0;
      end else begin
        m_pul[c] = 0;
        if (m_s2[c] != m_lvl[c]) begin
          m_cnt[c]++;
          if (m_cnt[c] == DB + 1) begin
            m_lvl[c] = m_s2[c];
            m_cnt[c] = 0;
            m_since[c] = 0;
            m_ph[c] = 0;
            if (m_lvl[c]) m_pul[c] = 1;
          end
        end else if (m_cnt[c] != 0) begin
          m_cnt[c] = 0;
          m_since[c] = 0;
          m_ph[c] = 0;
        end else if (m_lvl[c] && c == 1) begin
          m_since[c]++;
          if (m_since[c] == (m_ph[c] ? RP : RD)) begin
            m_pul[c] = 1;
            m_since[c] = 0;
            m_ph[c] = 1;
          end
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = m_raw[c];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model mode_switch", mode_switch, m_pul[0]);
      chk("model ext_counter", ext_counter, m_pul[1]);
      chk("model btn_mode_level", btn_mode_level, m_lvl[0]);
      chk("model btn_count_level", btn_count_level, m_lvl[1]);
    end
  end

  // Directed scenarios: patterns indexed by t (t=0 is the first sampling edge).
  bit pm[64], pc[64], pr[64];
  int q_mp[$], q_cp[$], q_ml[$], q_cl[$], ex[$];
  int snap_t;
  int snap;

  task automatic clear_pat();
    for (int i = 0; i < 64; i++) begin
      pm[i] = 0; pc[i] = 0; pr[i] = 1;
    end
    snap_t = -1;
    snap = -1;
  endtask

  task automatic run_scn(input int len);
    logic pml, pcl;
    q_mp.delete(); q_cp.delete(); q_ml.delete(); q_cl.delete();
    pml = btn_mode_level;
    pcl = btn_count_level;
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      btn_mode_in  = pm[t];
      btn_count_in = pc[t];
      resetn       = pr[t];
      @(posedge clk);
      #1;
      if (mode_switch) q_mp.push_back(t);
      if (ext_counter) q_cp.push_back(t);
      if (btn_mode_level != pml) q_ml.push_back(t);
      if (btn_count_level != pcl) q_cl.push_back(t);
      pml = btn_mode_level;
      pcl = btn_count_level;
      if (t == snap_t)
        snap = int'({mode_switch, ext_counter, btn_mode_level, btn_count_level});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btn_mode_in = 0; btn_count_in = 0; resetn = 1;
    end
  endtask

  initial begin
    resetn = 0; btn_mode_in = 0; btn_count_in = 0;
    @(posedge clk);
    #1;
    chk_en = 1;
    chk("reset mode_switch", mode_switch, 0);
    chk("reset ext_counter", ext_counter, 0);
    chk("reset btn_mode_level", btn_mode_level, 0);
    chk("reset btn_count_level", btn_count_level, 0);
    repeat (2) @(negedge clk);
    idle(20);

    // Clean press on mode button.
    clear_pat();
    for (int t = 0; t < 20; t++) pm[t] = 1;
    snap_t = 6;
    run_scn(40);
    ex = '{6};      chk_q("clean mode pulses", q_mp, ex);
    ex = '{6, 26};  chk_q("clean mode level edges", q_ml, ex);
    ex.delete();    chk_q("clean count pulses", q_cp, ex);
    chk("clean outputs at t6", snap, 4'b1010);
    idle(20);

    // Bounce on count button.
    clear_pat();
    pc[0] = 1; pc[2] = 1;
    for (int t = 4; t < 14; t++) pc[t] = 1;
    run_scn(35);
    ex = '{10};     chk_q("bounce count pulses", q_cp, ex);
    ex = '{10, 20}; chk_q("bounce count level edges", q_cl, ex);
    idle(20);

    // Short glitch on mode button.
    clear_pat();
    for (int t = 0; t < 3; t++) pm[t] = 1;
    run_scn(20);
    ex.delete();    chk_q("glitch mode pulses", q_mp, ex);
    ex.delete();    chk_q("glitch mode level edges", q_ml, ex);
    idle(20);

    // Hold-to-repeat on count button.
    clear_pat();
    for (int t = 0; t < 30; t++) pc[t] = 1;
    run_scn(50);
    ex = '{6, 16, 19, 22, 25, 28, 31}; chk_q("hold count pulses", q_cp, ex);
    ex = '{6, 36};                     chk_q("hold count level edges", q_cl, ex);
    idle(20);

    // Reset while the count button is held and repeating.
    clear_pat();
    for (int t = 0; t < 40; t++) pc[t] = 1;
    pr[20] = 0; pr[21] = 0;
    snap_t = 21;
    run_scn(55);
    ex = '{6, 16, 19, 28, 38, 41}; chk_q("reset count pulses", q_cp, ex);
    ex = '{6, 20, 28, 46};         chk_q("reset count level edges", q_cl, ex);
    chk("reset outputs at t21", snap, 0);
    idle(20);

    // Both buttons together: only the count channel repeats.
    clear_pat();
    for (int t = 0; t < 30; t++) begin
      pm[t] = 1; pc[t] = 1;
    end
    run_scn(50);
    ex = '{6};                         chk_q("simul mode pulses", q_mp, ex);
    ex = '{6, 16, 19, 22, 25, 28, 31}; chk_q("simul count pulses", q_cp, ex);
    ex = '{6, 36};                     chk_q("simul mode level edges", q_ml, ex);
    idle(20);

    // Random bouncing/holding with occasional resets, checked by the model.
    for (int blk = 0; blk < 8; blk++) begin
      int lim;
      lim = (blk % 2 == 0) ? 3 : 40;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if ($urandom_range(0, lim - 1) == 0) btn_mode_in = ~btn_mode_in;
        if ($urandom_range(0, lim - 1) == 0) btn_count_in = ~btn_count_in;
        resetn = ($urandom_range(0, 599) != 0);
      end
    end
    idle(30);

    @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/button_pulser.md
# button_pulser

Input conditioner that feeds the LED counter block. It turns two raw, bouncing push-buttons into the single-cycle `mode_switch` and `ext_counter` pulses that block consumes. Each channel has its own synchronizer, debounce state machine and edge-to-pulse logic. The count channel adds hold-to-repeat. It sits between the board pins and the LED counter, in the same `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, 16'd50000: consecutive stable cycles required to accept a level change; ≥2.
- `REPEAT_DELAY`, 24'd5000000: cycles from the press pulse to the first repeat pulse (count channel only); ≥1.
- `REPEAT_PERIOD`, 24'd2500000: cycles between repeat pulses; ≥1.
- `clk`  input  1  sole clock.
- `resetn`  input  1  synchronous, active-low reset.
- `btn_mode_in`  input  1  raw mode button, asynchronous, active-high.
- `btn_count_in`  input  1  raw count button, asynchronous, active-high.
- `mode_switch`  output  1  one-cycle pulse per accepted mode press.
- `ext_counter`  output  1  one-cycle pulse per accepted count press and per repeat.
- `btn_mode_level`  output  1  debounced mode button level.
- `btn_count_level`  output  1  debounced count button level.

## Operation
- Each raw input passes through a 2-flop synchronizer (reset 0). The output of that synchronizer is `sync_in`.
- Per-channel FSM states: IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT. There is one timer per channel, sized to the largest parameter.
- IDLE (level 0):
  - `sync_in`=1 → PRESS_WAIT; timer=1.
- PRESS_WAIT:
  - `sync_in`=0 → IDLE; no pulse.
  - Timer reaches DEBOUNCE_CYCLES with `sync_in` still 1 → HELD. Pulse and level=1 are registered on the next edge.
- HELD (level 1):
  - `sync_in`=0 → RELEASE_WAIT; timer=1.
  - Repeat enabled and timer reaches REPEAT_DELAY → pulse, then REPEAT.
  - Mode channel has repeat disabled and stays in HELD.
- REPEAT:
  - Pulse every REPEAT_PERIOD cycles.
  - `sync_in`=0 → RELEASE_WAIT.
- RELEASE_WAIT:
  - `sync_in`=1 → HELD; repeat timer restarts; no pulse.
  - DEBOUNCE_CYCLES consecutive 0 → IDLE; level=0.
- Release never produces a pulse.
- Pulses are exactly one cycle wide. They are never merged or queued.
- The two channels are fully independent. Simultaneous presses give pulses in the same cycle when their timing matches.
- Timers saturate and never wrap. Comparison is against the parameter value, using unsigned arithmetic.

## Timing
- Reset: all outputs 0, FSMs in IDLE, synchronizers and timers 0. Takes effect on the first `clk` edge with `resetn`=0.
- Latency uses t=0 as the first edge that samples the raw input at its new value, held stable:
  - press pulse and level rise at t=DEBOUNCE_CYCLES+2;
  - level falls DEBOUNCE_CYCLES+2 after release.
- Repeat pulses occur at press pulse + REPEAT_DELAY, then every +REPEAT_PERIOD.
- Button held through reset: after `resetn` rises it is treated as a fresh press, with a pulse after full debounce.
- Reset mid-REPEAT: no pulse in or after the reset cycle until a new debounce completes.

## Structure
- A shared header holds:
  - FSM state encodings: 3-bit IDLE=0, PRESS_WAIT=1, HELD=2, REPEAT=3, RELEASE_WAIT=4;
  - the timer width function based on `$clog2` of the largest parameter.
- Sub-module `button_debounce` contains the synchronizer, FSM and timer.
  - Parameters: DEBOUNCE_CYCLES, REPEAT_EN, REPEAT_DELAY, REPEAT_PERIOD.
  - Ports: `clk`, `resetn`, `btn_in`, `pulse`, `level`.
- `button_pulser` instantiates it twice: mode channel with REPEAT_EN=0, count channel with REPEAT_EN=1.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: `btn_mode_in`=1 for 20 cycles from t=0 → `mode_switch` high only at t=6; `btn_mode_level` rises at t=6 and falls at t=26; no pulse on release.
- Bounce: `btn_count_in` goes 1,0,1,0, then stable 1 from t=4 → exactly one `ext_counter` pulse, at t=10.
- Glitch: `btn_mode_in` high for 3 cycles → no `mode_switch` pulse; level stays 0.
- Hold/repeat: `btn_count_in` high t=0..29 → `ext_counter` pulses at t=6, 16, 19, 22, 25, 28, 31 and none after; level falls at t=36.
- Reset mid-hold: `btn_count_in` held; `resetn`=0 at t=20–21 → all outputs 0 from t=21. First post-reset sample is t=22, so the new pulse is at t=28.
- Simultaneous: both buttons rise at t=0 → `mode_switch` and `ext_counter` both pulse at t=6; holding both gives repeats only on `ext_counter`.
